// File: rtl/spi_platform_designer_ram_arbiter_pkg.sv
// Shared widths, depth and constants for the two-port RAM arbiter.
// The out-of-range check in the top is enabled by SPI_RAM_ARB_RANGE_CHECK_EN.
package spi_ram_arb_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 20480;

    typedef logic port_id_t;

    localparam logic [31:0] ERR_READDATA = 32'h0000_0000;

endpackage

// File: rtl/spi_platform_designer_ram_arbiter_rr.sv
// Two-way round-robin picker: a lone requester always wins; on contention
// the port named by rr_ptr wins. The pointer itself lives in the parent.
module spi_ram_arb_rr
    import spi_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[0] && (!req[1] || (rr_ptr == 1'b0))) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_platform_designer_ram_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between two Avalon-MM masters.
// Define SPI_RAM_ARB_RANGE_CHECK_EN to block and flag accesses at or above DEPTH.
module spi_platform_designer_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = spi_ram_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = spi_ram_arb_pkg::DATA_W,
    parameter int unsigned DEPTH  = spi_ram_arb_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  err_flag,
    input  logic                  err_clear
);

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    port_id_t            w_sel;
    logic                w_accept;
    logic                w_is_write;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_rdata;

    port_id_t            r_rr_ptr;
    logic                r_rd_valid;
    port_id_t            r_rd_id;
    logic                r_rd_blocked;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    spi_ram_arb_rr u_rr (
        .req    (w_req),
        .rr_ptr (r_rr_ptr),
        .grant  (w_grant)
    );

    assign w_sel      = w_grant[1];
    assign w_accept   = (|w_grant) & ~reset;
    assign w_is_write = w_sel ? m1_write : m0_write;
    assign w_addr     = w_sel ? m1_address : m0_address;

    assign m0_waitrequest = reset | (w_req[0] & ~w_grant[0]);
    assign m1_waitrequest = reset | (w_req[1] & ~w_grant[1]);

`ifdef SPI_RAM_ARB_RANGE_CHECK_EN
    logic r_err;

    assign w_in_range = (32'(w_addr) < DEPTH);
    assign err_flag   = r_err;

    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_err <= 1'b1;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_in_range = 1'b1;
    assign err_flag   = 1'b0;
    assign w_unused   = err_clear | (DEPTH == 0);
`endif

    assign ram_address    = w_addr;
    assign ram_byteenable = w_sel ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_sel ? m1_writedata : m0_writedata;
    assign ram_chipselect = w_accept & w_in_range;
    assign ram_write      = w_accept & w_in_range & w_is_write;
    assign ram_clken      = 1'b1;

    assign w_rdata = r_rd_blocked ? DATA_W'(ERR_READDATA) : ram_readdata;

    // RAM data is only valid in the return cycle, so it is forwarded live
    // and captured for the hold value seen in later cycles.
    assign m0_readdatavalid = r_rd_valid & (r_rd_id == 1'b0);
    assign m1_readdatavalid = r_rd_valid & (r_rd_id == 1'b1);
    assign m0_readdata      = m0_readdatavalid ? w_rdata : r_rdata0;
    assign m1_readdata      = m1_readdatavalid ? w_rdata : r_rdata1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_id      <= 1'b0;
            r_rd_blocked <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= ~w_sel;
            end
            r_rd_valid <= w_accept & ~w_is_write;
            if (w_accept && !w_is_write) begin
                r_rd_id      <= w_sel;
                r_rd_blocked <= ~w_in_range;
            end
            if (m0_readdatavalid) begin
                r_rdata0 <= w_rdata;
            end
            if (m1_readdatavalid) begin
                r_rdata1 <= w_rdata;
            end
        end
    end

endmodule

// File: doc/spi_platform_designer_ram_arbiter.md
# spi_platform_designer_ram_arbiter

Two-port round-robin arbiter that shares the single-port on-chip program/data RAM (32-bit, 20480 words, 1-cycle read latency) between two Avalon-MM requesters, e.g. the Nios II data master and the SPI DMA engine. It sits between the two masters and the RAM's s1 slave. Each cycle it grants at most one transfer, drives the RAM's address, byteenable, chipselect and write signals, and routes the returned read data back to the requester that issued the read.

## Interface
- ADDR_W, 15, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 20480, number of implemented RAM words.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes, applied to writes only.
- m0_read, m0_write / m1_read, m1_write  in  1  request strobes; never both high on one port.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  stall; the transfer is accepted when the strobe is high and waitrequest is low.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read-data strobe.
- ram_address  out  ADDR_W; ram_byteenable  out  DATA_W/8; ram_chipselect  out  1; ram_write  out  1; ram_writedata  out  DATA_W; ram_clken  out  1 (tied high).
- ram_readdata  in  DATA_W  unregistered RAM output, valid one cycle after the address.
- err_flag  out  1  sticky out-of-range flag (macro only).
- err_clear  in  1  clears err_flag (macro only).

## Operation
- Request: port i requests when mi_read or mi_write is high.
- Grant: combinational, at most one grant per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port selected by rr_ptr is granted.
- rr_ptr: 1-bit register. On every accepted transfer it is set to the other port, so contention strictly alternates m0, m1, m0, …
- Waitrequest:
  - mi_waitrequest = request_i & ~grant_i.
  - An idle port sees waitrequest low.
  - While reset is asserted, both waitrequest outputs are forced high.
- RAM drive:
  - The granted port's address, byteenable and writedata pass straight through.
  - ram_chipselect = any grant.
  - ram_write = granted write.
  - With no grant, ram_chipselect and ram_write are 0 and the other RAM outputs are don't-care.
- Read return:
  - An accepted read loads rd_valid=1 and rd_id=port.
  - Next cycle: m[rd_id]_readdata = ram_readdata and m[rd_id]_readdatavalid = 1.
  - Back-to-back reads, including alternating ports, are fully pipelined.
- readdata of the non-addressed port holds its last value.
- Reset values: rr_ptr=0 (m0 first), rd_valid=0, rd_id=0, both readdatavalid=0, both readdata=0, err_flag=0.
- Reset mid-read: the pending readdatavalid is discarded and not re-issued.

## Timing
- Cycle N: transfer accepted.
  - A write commits to the RAM at the rising edge that ends cycle N.
  - A read returns data with readdatavalid in cycle N+1.
- Sustained throughput is 1 transfer/cycle in aggregate.
  - Under contention each port gets 1 transfer every 2 cycles.
  - The maximum wait for either port is 1 cycle.
- Write by m0 in cycle N followed by a read of the same address by m1 in cycle N+1: m1 receives the new data in N+2.
- A same-cycle read-during-write cannot occur, because only one grant is issued per cycle.

## Configuration
- SPI_RAM_ARB_RANGE_CHECK_EN defined:
  - An accepted transfer with address >= DEPTH is blocked: ram_chipselect=0 and ram_write=0.
  - The transfer is still accepted (waitrequest behaves normally) and rr_ptr still toggles.
  - A blocked read returns readdatavalid in N+1 with readdata = 32'h0000_0000.
  - err_flag sets in the cycle after the blocked transfer is accepted.
  - err_flag clears on err_clear; if a new error and err_clear occur in the same cycle, set wins.
- SPI_RAM_ARB_RANGE_CHECK_EN undefined:
  - The address passes unchecked.
  - err_flag is tied 0 and err_clear is ignored.

## Structure
- Package spi_ram_arb_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults;
  - typedef port_id_t (1-bit);
  - constant ERR_READDATA = 0.
- One sub-module, spi_ram_arb_rr: the 2-way round-robin picker.
  - Inputs: req[1:0], rr_ptr.
  - Output: grant[1:0].
  - Pointer update stays in the parent.

## Test plan
- Reset released, m0 writes 0xA5A5_1234 to address 0x0010, then reads it -> waitrequest is 0 on both cycles; m0_readdatavalid pulses one cycle after the read with 0xA5A5_1234.
- m0 and m1 read addresses 0x0001 and 0x0002 continuously from the same cycle -> grants go m0, m1, m0, m1; each readdatavalid lands on the correct port with the correct word; each port's waitrequest is high every other cycle.
- Byteenable 4'b0010 write of 0xFFFF_FFFF over 0x0000_0000 -> readback is 0x0000_FF00.
- m1 writes 0x1 to 0x0100 in cycle N, m0 reads 0x0100 in cycle N+1 -> m0_readdata is 0x1 in N+2.
- Reset asserted in the cycle after an accepted read -> no readdatavalid; after release, rr_ptr=0, so under contention m0 is granted first.
- With SPI_RAM_ARB_RANGE_CHECK_EN: m0 writes to address 20480, then reads it -> no ram_chipselect; read returns 0x0 with readdatavalid; err_flag=1 until err_clear is pulsed.
